sum_accum: RTL

//   Downstream consumer of the WIDTH-bit adder's (WIDTH+1)-bit sum output.

---
 rtl/sum_accum_pkg.sv | 24 ++
 rtl/sum_accum_ctr.sv | 29 ++
 rtl/sum_accum.sv | 112 +++++++++++
 3 files changed

// File: rtl/sum_accum_pkg.sv
// Shared types and width helpers for the sum accumulator.
// st_e frame FSM states; acc_width/cnt_width size the total and counter.
package sum_accum_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } st_e;

  function automatic int acc_width(
    input int w,
    input int d
  );
    return w + 1 + $clog2(d);
  endfunction

  function automatic int cnt_width(
    input int d
  );
    return $clog2(d + 1);
  endfunction

endpackage

// File: rtl/sum_accum_ctr.sv
// Sample counter for one frame of DEPTH accepted beats.
// Ports: i_clk, i_rst, inc, clr -> count, last (final beat of frame).
module sum_accum_ctr
  import sum_accum_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             last
);

  assign last = inc & (count == CNT_W'(DEPTH - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sum_accum.sv
// Accumulates DEPTH adder sums per frame; total out via valid/ready.
// Ports: i_sum/valid/ready in, i_clear abort, o_acc/valid/ready out, o_count.
// Optional o_avg (frame mean) under macro SUM_ACC_AVG_EN.
module sum_accum
  import sum_accum_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int DEPTH = 8,
  localparam int ACC_W = acc_width(WIDTH, DEPTH),
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [WIDTH:0]   i_sum,
  input  logic             i_sum_valid,
  output logic             o_sum_ready,
  input  logic             i_clear,
  output logic [ACC_W-1:0] o_acc,
  output logic             o_acc_valid,
  input  logic             i_acc_ready,
  output logic [CNT_W-1:0] o_count
`ifdef SUM_ACC_AVG_EN
  ,
  output logic [WIDTH:0]   o_avg
`endif
);

  st_e              state;
  logic [ACC_W-1:0] acc;
  logic             acc_valid;
  logic             in_beat;
  logic             out_beat;
  logic             last;

  if (DEPTH < 1) begin : g_bad_depth
    $error("sum_accum: DEPTH must be >= 1");
  end

  // Ready comes from state alone so it never depends on i_sum_valid.
  assign o_sum_ready = (state != DONE) & ~i_rst;
  assign in_beat     = i_sum_valid & o_sum_ready;
  assign out_beat    = acc_valid & i_acc_ready;

  sum_accum_ctr #(
    .DEPTH(DEPTH)
  ) u_ctr (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .inc  (in_beat & ~i_clear),
    .clr  (i_clear | out_beat),
    .count(o_count),
    .last (last)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      acc       <= '0;
      acc_valid <= 1'b0;
    end else if (i_clear) begin
      state     <= IDLE;
      acc       <= '0;
      acc_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_beat) begin
            acc       <= ACC_W'(i_sum);
            state     <= last ? DONE : ACCUM;
            acc_valid <= last;
          end
        end
        ACCUM: begin
          if (in_beat) begin
            acc <= acc + ACC_W'(i_sum);
            if (last) begin
              state     <= DONE;
              acc_valid <= 1'b1;
            end
          end
        end
        DONE: begin
          if (i_acc_ready) begin
            acc       <= '0;
            state     <= IDLE;
            acc_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          acc       <= '0;
          acc_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_acc       = acc;
  assign o_acc_valid = acc_valid;

`ifdef SUM_ACC_AVG_EN
  localparam int AVG_SH = $clog2(DEPTH);

  if ((DEPTH & (DEPTH - 1)) != 0) begin : g_bad_avg
    $error("sum_accum: averaging needs a power-of-two DEPTH");
  end

  // ACC_W is exactly WIDTH+1+AVG_SH, so the mean is the top slice.
  assign o_avg = acc[AVG_SH +: WIDTH + 1];
`endif

endmodule
